trigger_pulse_shaper: RTL and testbench

- Sits directly downstream of the trigger sequencer and consumes its single-bit trigger output.
- Applies a programmable delay, output pulse width and holdoff to each accepted trigger, and optionally stops after N triggers per arm.
- Drives the capture-start trigger into the ADC capture logic.
- Reports accepted and missed trigger counts for register readback.

---
 rtl/trigger_pulse_shaper.sv | 160 ++++++++++++++++
 tb/tb_trigger_pulse_shaper.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_pulse_shaper.sv
// Shapes sequenced triggers into capture-start pulses with programmable delay,
// width and holdoff, an optional per-arm trigger limit and accepted/missed counters.
module trigger_pulse_shaper #(
  parameter int pDELAY_WIDTH = 16,
  parameter int pWIDTH_WIDTH = 8,
  parameter int pCOUNT_WIDTH = 16
) (
  input  logic                    adc_clk,
  input  logic                    reset_n,
  input  logic                    armed_and_ready,
  input  logic                    I_trigger,
  input  logic [pDELAY_WIDTH-1:0] I_delay,
  input  logic [pWIDTH_WIDTH-1:0] I_width,
  input  logic [pDELAY_WIDTH-1:0] I_holdoff,
  input  logic [pCOUNT_WIDTH-1:0] I_max_triggers,
  output logic                    O_trigger,
  output logic                    O_busy,
  output logic                    O_done,
  output logic [pCOUNT_WIDTH-1:0] O_trigger_count,
  output logic [pCOUNT_WIDTH-1:0] O_missed_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    DELAY   = 3'd2,
    PULSE   = 3'd3,
    HOLDOFF = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic                    trig_r_q, trig_r2_q;
  logic                    otrig_q;
  logic [pDELAY_WIDTH-1:0] cnt_q, cnt_d;
  logic [pWIDTH_WIDTH-1:0] wcnt_q, wcnt_d;
  logic [pWIDTH_WIDTH-1:0] width_q, width_d;
  logic [pDELAY_WIDTH-1:0] holdoff_q, holdoff_d;
  logic [pCOUNT_WIDTH-1:0] trig_count_q, trig_count_d;
  logic [pCOUNT_WIDTH-1:0] missed_q, missed_d;
  logic                    edge_det;
  logic                    limit_hit;
  state_t                  post_pulse;

  function automatic logic [pCOUNT_WIDTH-1:0] sat_inc(input logic [pCOUNT_WIDTH-1:0] v);
    return (v == {pCOUNT_WIDTH{1'b1}}) ? v : v + pCOUNT_WIDTH'(1);
  endfunction

  function automatic logic [pWIDTH_WIDTH-1:0] eff_width(input logic [pWIDTH_WIDTH-1:0] w);
    return (w == '0) ? pWIDTH_WIDTH'(1) : w;
  endfunction

  assign edge_det   = trig_r_q & ~trig_r2_q;
  assign limit_hit  = (I_max_triggers != '0) && (trig_count_q >= I_max_triggers);
  assign post_pulse = limit_hit ? DONE : ARMED;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wcnt_d       = wcnt_q;
    width_d      = width_q;
    holdoff_d    = holdoff_q;
    trig_count_d = trig_count_q;
    missed_d     = missed_q;

    case (state_q)
      IDLE: begin
        if (armed_and_ready) begin
          state_d      = ARMED;
          trig_count_d = '0;
          missed_d     = '0;
        end
      end
      ARMED: begin
        if (edge_det) begin
          width_d   = I_width;
          holdoff_d = I_holdoff;
          if (I_delay == '0) begin
            state_d      = PULSE;
            wcnt_d       = eff_width(I_width);
            trig_count_d = sat_inc(trig_count_q);
          end else begin
            state_d = DELAY;
            cnt_d   = I_delay;
          end
        end
      end
      DELAY: begin
        if (edge_det) missed_d = sat_inc(missed_q);
        if (cnt_q == pDELAY_WIDTH'(1)) begin
          state_d      = PULSE;
          wcnt_d       = eff_width(width_q);
          trig_count_d = sat_inc(trig_count_q);
        end else begin
          cnt_d = cnt_q - pDELAY_WIDTH'(1);
        end
      end
      PULSE: begin
        if (edge_det) missed_d = sat_inc(missed_q);
        if (wcnt_q == pWIDTH_WIDTH'(1)) begin
          if (holdoff_q == '0) begin
            state_d = post_pulse;
          end else begin
            state_d = HOLDOFF;
            cnt_d   = holdoff_q;
          end
        end else begin
          wcnt_d = wcnt_q - pWIDTH_WIDTH'(1);
        end
      end
      HOLDOFF: begin
        if (edge_det) missed_d = sat_inc(missed_q);
        if (cnt_q == pDELAY_WIDTH'(1)) state_d = post_pulse;
        else                           cnt_d   = cnt_q - pDELAY_WIDTH'(1);
      end
      DONE: ;
      default: state_d = IDLE;
    endcase

    // Disarm wins from any state; counts freeze for readback until the next arm.
    if (!armed_and_ready) begin
      state_d      = IDLE;
      trig_count_d = trig_count_q;
      missed_d     = missed_q;
    end
  end

  always_ff @(posedge adc_clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      trig_r_q     <= 1'b0;
      trig_r2_q    <= 1'b0;
      otrig_q      <= 1'b0;
      trig_count_q <= '0;
      missed_q     <= '0;
    end else begin
      state_q      <= state_d;
      trig_r_q     <= I_trigger;
      trig_r2_q    <= trig_r_q;
      otrig_q      <= (state_q == PULSE) && armed_and_ready;
      trig_count_q <= trig_count_d;
      missed_q     <= missed_d;
    end
  end

  // Timing/latch registers are only read in states that load them first.
  always_ff @(posedge adc_clk) begin
    cnt_q     <= cnt_d;
    wcnt_q    <= wcnt_d;
    width_q   <= width_d;
    holdoff_q <= holdoff_d;
  end

  assign O_trigger       = otrig_q;
  assign O_busy          = (state_q == DELAY) || (state_q == PULSE) || (state_q == HOLDOFF);
  assign O_done          = (state_q == DONE);
  assign O_trigger_count = trig_count_q;
  assign O_missed_count  = missed_q;

endmodule

// File: tb/tb_trigger_pulse_shaper.sv
// Directed bench for trigger_pulse_shaper: a vector table of delay/width/holdoff
// settings plus hand-written sequences for holdoff, trigger limit, disarm and reset.
module tb_trigger_pulse_shaper;

  logic        adc_clk = 1'b0;
  logic        reset_n;
  logic        armed_and_ready;
  logic        I_trigger;
  logic [15:0] I_delay;
  logic [7:0]  I_width;
  logic [15:0] I_holdoff;
  logic [15:0] I_max_triggers;
  logic        O_trigger;
  logic        O_busy;
  logic        O_done;
  logic [15:0] O_trigger_count;
  logic [15:0] O_missed_count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] delay;
    logic [7:0]  width;
    logic [15:0] holdoff;
    int          exp_first;
    int          exp_len;
  } vec_t;

  vec_t vecs[6];

  trigger_pulse_shaper dut (
    .adc_clk         (adc_clk),
    .reset_n         (reset_n),
    .armed_and_ready (armed_and_ready),
    .I_trigger       (I_trigger),
    .I_delay         (I_delay),
    .I_width         (I_width),
    .I_holdoff       (I_holdoff),
    .I_max_triggers  (I_max_triggers),
    .O_trigger       (O_trigger),
    .O_busy          (O_busy),
    .O_done          (O_done),
    .O_trigger_count (O_trigger_count),
    .O_missed_count  (O_missed_count)
  );

  always #5 adc_clk = ~adc_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge adc_clk);
    #1;
  endtask

  task automatic rearm();
    armed_and_ready = 1'b0;
    step();
    armed_and_ready = 1'b1;
    step();
  endtask

  task automatic run_vec(input vec_t v, output int first, output int len);
    int win;
    win = int'(v.delay) + int'(v.width) + int'(v.holdoff) + 12;
    I_delay   = v.delay;
    I_width   = v.width;
    I_holdoff = v.holdoff;
    I_trigger = 1'b1;
    first = -1;
    len   = 0;
    for (int i = 0; i < win; i++) begin
      step();
      if (i == 0) I_trigger = 1'b0;
      if (O_trigger) begin
        if (first < 0) first = i;
        len++;
      end
    end
  endtask

  initial begin
    int first, len, highs, busy_mid, waited;
    string nm;

    vecs[0] = '{16'd5,  8'd3,   16'd0, 7,  3};
    vecs[1] = '{16'd0,  8'd0,   16'd0, 2,  1};
    vecs[2] = '{16'd1,  8'd1,   16'd0, 3,  1};
    vecs[3] = '{16'd0,  8'd4,   16'd3, 2,  4};
    vecs[4] = '{16'd12, 8'd255, 16'd2, 14, 255};
    vecs[5] = '{16'd2,  8'd0,   16'd0, 4,  1};

    reset_n         = 1'b0;
    armed_and_ready = 1'b0;
    I_trigger       = 1'b1;
    I_delay         = '0;
    I_width         = '0;
    I_holdoff       = '0;
    I_max_triggers  = '0;

    // Reset held with trigger high
    repeat (3) step();
    check("reset_trigger", O_trigger, 0);
    check("reset_busy", O_busy, 0);
    check("reset_done", O_done, 0);
    check("reset_trig_count", O_trigger_count, 0);
    check("reset_missed_count", O_missed_count, 0);
    I_trigger = 1'b0;
    reset_n   = 1'b1;
    repeat (3) step();
    armed_and_ready = 1'b1;
    step();
    check("armed_idle_busy", O_busy, 0);

    // Table of delay/width/holdoff settings
    foreach (vecs[j]) begin
      run_vec(vecs[j], first, len);
      nm = $sformatf("vec%0d_first", j);
      check(nm, first, vecs[j].exp_first);
      nm = $sformatf("vec%0d_len", j);
      check(nm, len, vecs[j].exp_len);
      nm = $sformatf("vec%0d_count", j);
      check(nm, O_trigger_count, j + 1);
    end
    check("table_missed", O_missed_count, 0);

    // Level held high gives a single pulse
    I_delay = 16'd0; I_width = 8'd1; I_holdoff = 16'd0;
    I_trigger = 1'b1;
    highs = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (O_trigger) highs++;
    end
    I_trigger = 1'b0;
    repeat (3) step();
    check("level_pulses", highs, 1);
    check("level_count", O_trigger_count, 7);

    // Holdoff rejection: triggers at 0, 6, 12, 30
    rearm();
    check("rearm_clear_count", O_trigger_count, 0);
    I_delay = 16'd2; I_width = 8'd2; I_holdoff = 16'd10;
    highs = 0; busy_mid = 0;
    for (int t = 0; t <= 50; t++) begin
      I_trigger = (t == 0 || t == 6 || t == 12 || t == 30);
      step();
      if (O_trigger) highs++;
      if (t == 10) busy_mid = O_busy;
    end
    I_trigger = 1'b0;
    check("holdoff_high_cycles", highs, 4);
    check("holdoff_busy_mid", busy_mid, 1);
    check("holdoff_trig_count", O_trigger_count, 2);
    check("holdoff_missed", O_missed_count, 2);

    // Trigger limit of two per arm
    rearm();
    check("rearm_clear_missed", O_missed_count, 0);
    I_delay = 16'd1; I_width = 8'd1; I_holdoff = 16'd0; I_max_triggers = 16'd2;
    highs = 0;
    for (int t = 0; t <= 45; t++) begin
      I_trigger = (t == 0 || t == 10 || t == 20 || t == 30);
      step();
      if (O_trigger) highs++;
    end
    I_trigger = 1'b0;
    check("max_pulses", highs, 2);
    check("max_done", O_done, 1);
    check("max_busy", O_busy, 0);
    check("max_trig_count", O_trigger_count, 2);
    check("max_missed", O_missed_count, 0);
    armed_and_ready = 1'b0;
    step();
    check("disarm_done", O_done, 0);
    check("disarm_hold_count", O_trigger_count, 2);

    // Disarm in the middle of a long delay
    armed_and_ready = 1'b1;
    step();
    check("arm_clear_count", O_trigger_count, 0);
    I_max_triggers = 16'd0;
    I_delay = 16'd100; I_width = 8'd3; I_holdoff = 16'd0;
    highs = 0; busy_mid = 0;
    for (int t = 0; t <= 130; t++) begin
      I_trigger = (t == 0);
      if (t == 21) armed_and_ready = 1'b0;
      step();
      if (O_trigger) highs++;
      if (t == 10) busy_mid = O_busy;
    end
    check("disarm_delay_busy_before", busy_mid, 1);
    check("disarm_no_pulse", highs, 0);
    check("disarm_busy_after", O_busy, 0);
    rearm();
    check("disarm_rearm_count", O_trigger_count, 0);

    // Reset in the middle of a pulse
    I_delay = 16'd0; I_width = 8'd10; I_holdoff = 16'd0;
    I_trigger = 1'b1;
    waited = 0;
    while (!O_trigger && waited < 20) begin
      step();
      I_trigger = 1'b0;
      waited++;
    end
    check("midpulse_reached", O_trigger, 1);
    reset_n = 1'b0;
    step();
    check("midpulse_reset_drop", O_trigger, 0);
    check("midpulse_reset_count", O_trigger_count, 0);
    reset_n = 1'b1;
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (O_trigger) highs++;
    end
    check("midpulse_no_resume", highs, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
